i2d_imem: RTL and testbench

//   Wishbone-style instruction memory responder; the slave end of the i2d fetch interface.
//   - Answers every fetch-unit access with exactly one of ack/rty/err in the same cycle as the request.
//   - Inserts programmable wait states, signalled as rty.
//   - Contains a word-addressed preload port used by the test host and boot loader.

---
 rtl/i2d_imem.sv | 101 ++++++++++
 tb/tb_i2d_imem.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2d_imem.sv
// Instruction memory responder for the i2d fetch bus: ack/rty/err in the request cycle, WAIT_STATES rty cycles per new access.
// Optional I2D_IMEM_ALIGN_CHECK_EN: misaligned byte addresses report err_o instead of returning the enclosing word.
module i2d_imem #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic [31:0]          adr_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 rty_o,
    output logic                 err_o,
    input  logic                 ld_we,
    input  logic [ADDR_BITS-1:0] ld_adr,
    input  logic [31:0]          ld_dat
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [31:0] mem_q [DEPTH];

    logic        active_q, active_d;
    logic [31:0] act_adr_q, act_adr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        req;
    logic [29:0] widx;
    logic        range_fault;
    logic        fault;
    logic        new_acc;
    logic [3:0]  eff;

    assign req         = cyc_i & stb_i;
    assign widx        = adr_i[31:2];
    assign range_fault = {2'b00, widx} >= 32'(DEPTH);

`ifdef I2D_IMEM_ALIGN_CHECK_EN
    assign fault = range_fault | (adr_i[1:0] != 2'b00);
`else
    assign fault = range_fault;
`endif

    // A held request at the same address resumes the pending count.
    assign new_acc = req & (~active_q | (adr_i != act_adr_q));
    assign eff     = new_acc ? WS : cnt_q;

    always_comb begin
        ack_o     = 1'b0;
        rty_o     = 1'b0;
        err_o     = 1'b0;
        dat_o     = 32'h0;
        active_d  = active_q;
        act_adr_d = act_adr_q;
        cnt_d     = cnt_q;
        if (!rst) begin
            rty_o = req;
        end else if (req) begin
            if (fault) begin
                err_o    = 1'b1;
                active_d = 1'b0;
            end else if (ld_we) begin
                // Preload owns the array this cycle; the wait count is frozen, not consumed.
                rty_o     = 1'b1;
                active_d  = 1'b1;
                act_adr_d = adr_i;
                cnt_d     = eff;
            end else if (eff != 4'd0) begin
                rty_o     = 1'b1;
                active_d  = 1'b1;
                act_adr_d = adr_i;
                cnt_d     = eff - 4'd1;
            end else begin
                ack_o    = 1'b1;
                dat_o    = mem_q[widx[ADDR_BITS-1:0]];
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
        act_adr_q <= act_adr_d;
    end

    always_ff @(posedge clk) begin
        if (ld_we && (32'(ld_adr) < 32'(DEPTH))) begin
            mem_q[ld_adr] <= ld_dat;
        end
    end

endmodule

// File: tb/tb_i2d_imem.sv
// Directed bench for i2d_imem: three instances (WAIT_STATES 1/0/3) share one stimulus stream.
module tb_i2d_imem;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb;
    logic [31:0] adr;
    logic        ld_we;
    logic [9:0]  ld_adr;
    logic [31:0] ld_dat;

    logic [31:0] dat_w1, dat_w0, dat_w3;
    logic        ack_w1, rty_w1, err_w1;
    logic        ack_w0, rty_w0, err_w0;
    logic        ack_w3, rty_w3, err_w3;

    logic [2:0]  r_w1, r_w0, r_w3;
    assign r_w1 = {ack_w1, rty_w1, err_w1};
    assign r_w0 = {ack_w0, rty_w0, err_w0};
    assign r_w3 = {ack_w3, rty_w3, err_w3};

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] ACK  = 3'b100;
    localparam logic [2:0] RTY  = 3'b010;
    localparam logic [2:0] ERR  = 3'b001;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2d_imem #(.DEPTH(1024), .ADDR_BITS(10), .WAIT_STATES(1)) u_w1 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .dat_o(dat_w1), .ack_o(ack_w1), .rty_o(rty_w1), .err_o(err_w1),
        .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat));

    i2d_imem #(.DEPTH(1000), .ADDR_BITS(10), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .dat_o(dat_w0), .ack_o(ack_w0), .rty_o(rty_w0), .err_o(err_w0),
        .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat));

    i2d_imem #(.DEPTH(1024), .ADDR_BITS(10), .WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .dat_o(dat_w3), .ack_o(ack_w3), .rty_o(rty_w3), .err_o(err_w3),
        .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input logic r, input logic [31:0] a);
        cyc = r;
        stb = r;
        adr = a;
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] d);
        ld_we  = 1'b1;
        ld_adr = idx;
        ld_dat = d;
        nxt();
        ld_we  = 1'b0;
    endtask

    logic [31:0] t2_adr [3];
    logic [31:0] t2_dat [3];
    logic [31:0] t4_adr [6];
    logic [2:0]  t4_rsp [6];

    initial begin
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; adr = 32'h0;
        ld_we = 1'b0; ld_adr = 10'd0; ld_dat = 32'h0;
        nxt();
        nxt();

        load(10'd0, 32'h1234_5678);
        load(10'd1, 32'hA1A1_0001);
        load(10'd2, 32'hB2B2_0002);
        load(10'd5, 32'h5555_5555);

        // In reset: rty mirrors req, nothing else.
        setreq(1'b1, 32'h0);
        chk("rst_w1_rsp", 32'(r_w1), 32'(RTY));
        chk("rst_w1_dat", dat_w1, 32'h0);
        chk("rst_w0_rsp", 32'(r_w0), 32'(RTY));
        chk("rst_w3_rsp", 32'(r_w3), 32'(RTY));
        nxt();
        rst = 1'b1;
        setreq(1'b0, 32'h0);
        chk("idle_w1_rsp", 32'(r_w1), 32'(IDLE));
        nxt();

        // Test 1: one wait state then ack
        setreq(1'b1, 32'h0);
        chk("t1_w1_c1_rsp", 32'(r_w1), 32'(RTY));
        chk("t1_w0_c1_rsp", 32'(r_w0), 32'(ACK));
        chk("t1_w0_c1_dat", dat_w0, 32'h1234_5678);
        chk("t1_w3_c1_rsp", 32'(r_w3), 32'(RTY));
        nxt();
        setreq(1'b1, 32'h0);
        chk("t1_w1_c2_rsp", 32'(r_w1), 32'(ACK));
        chk("t1_w1_c2_dat", dat_w1, 32'h1234_5678);
        nxt();

        // Test 2: zero wait states, streaming
        t2_adr = '{32'h0, 32'h4, 32'h8};
        t2_dat = '{32'h1234_5678, 32'hA1A1_0001, 32'hB2B2_0002};
        for (int i = 0; i < 3; i++) begin
            setreq(1'b1, t2_adr[i]);
            chk($sformatf("t2_w0_rsp%0d", i), 32'(r_w0), 32'(ACK));
            chk($sformatf("t2_w0_dat%0d", i), dat_w0, t2_dat[i]);
            nxt();
        end
        setreq(1'b0, 32'h0);
        chk("t2_idle_w0", 32'(r_w0), 32'(IDLE));
        chk("t2_idle_w1", 32'(r_w1), 32'(IDLE));
        chk("t2_idle_w3", 32'(r_w3), 32'(IDLE));
        nxt();

        // Test 3: range faults and last-word boundaries
        setreq(1'b1, 32'h0000_1000);
        chk("t3_w1_oor_rsp", 32'(r_w1), 32'(ERR));
        chk("t3_w1_oor_dat", dat_w1, 32'h0);
        chk("t3_w0_oor_rsp", 32'(r_w0), 32'(ERR));
        nxt();
        setreq(1'b1, 32'h0000_0FFC);
        chk("t3_w1_last_rsp", 32'(r_w1), 32'(RTY));
        chk("t3_w0_1023_rsp", 32'(r_w0), 32'(ERR));
        nxt();
        setreq(1'b1, 32'h0000_0F9C);
        chk("t3_w0_999_rsp", 32'(r_w0), 32'(ACK));
        nxt();
        setreq(1'b1, 32'h0000_0FA0);
        chk("t3_w0_1000_rsp", 32'(r_w0), 32'(ERR));
        nxt();
        setreq(1'b0, 32'h0);
        nxt();

        // Test 4: address change mid-wait restarts the count
        t4_adr = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4};
        t4_rsp = '{RTY, RTY, RTY, RTY, RTY, ACK};
        for (int i = 0; i < 6; i++) begin
            setreq(1'b1, t4_adr[i]);
            chk($sformatf("t4_w3_rsp%0d", i), 32'(r_w3), 32'(t4_rsp[i]));
            if (i == 5) chk("t4_w3_dat", dat_w3, 32'hA1A1_0001);
            nxt();
        end

        // Idle gap holds the count; same address resumes it
        setreq(1'b1, 32'h8);
        chk("hold_w3_a", 32'(r_w3), 32'(RTY));
        nxt();
        setreq(1'b0, 32'h8);
        chk("hold_w3_idle", 32'(r_w3), 32'(IDLE));
        nxt();
        nxt();
        setreq(1'b1, 32'h8);
        chk("hold_w3_b", 32'(r_w3), 32'(RTY));
        nxt();
        setreq(1'b1, 32'h8);
        chk("hold_w3_c", 32'(r_w3), 32'(RTY));
        nxt();
        setreq(1'b1, 32'h8);
        chk("hold_w3_ack", 32'(r_w3), 32'(ACK));
        chk("hold_w3_dat", dat_w3, 32'hB2B2_0002);
        nxt();

        // Test 5: preload during fetch of the same word
        ld_we = 1'b1; ld_adr = 10'd5; ld_dat = 32'hDEAD_BEEF;
        setreq(1'b1, 32'h14);
        chk("t5_w1_ld_rsp", 32'(r_w1), 32'(RTY));
        chk("t5_w0_ld_rsp", 32'(r_w0), 32'(RTY));
        nxt();
        ld_we = 1'b0;
        setreq(1'b1, 32'h14);
        chk("t5_w1_c2_rsp", 32'(r_w1), 32'(RTY));
        chk("t5_w0_c2_rsp", 32'(r_w0), 32'(ACK));
        chk("t5_w0_c2_dat", dat_w0, 32'hDEAD_BEEF);
        nxt();
        setreq(1'b1, 32'h14);
        chk("t5_w1_c3_rsp", 32'(r_w1), 32'(ACK));
        chk("t5_w1_c3_dat", dat_w1, 32'hDEAD_BEEF);
        nxt();

        // Test 6: misaligned address
        setreq(1'b1, 32'h2);
`ifdef I2D_IMEM_ALIGN_CHECK_EN
        chk("t6_w0_rsp", 32'(r_w0), 32'(ERR));
`else
        chk("t6_w0_rsp", 32'(r_w0), 32'(ACK));
        chk("t6_w0_dat", dat_w0, 32'h1234_5678);
`endif
        nxt();
        setreq(1'b0, 32'h0);
        nxt();

        // Reset mid-wait discards the pending count
        setreq(1'b1, 32'h4);
        chk("mr_w3_pre0", 32'(r_w3), 32'(RTY));
        nxt();
        setreq(1'b1, 32'h4);
        chk("mr_w3_pre1", 32'(r_w3), 32'(RTY));
        nxt();
        rst = 1'b0;
        setreq(1'b1, 32'h4);
        chk("mr_w3_inrst_rsp", 32'(r_w3), 32'(RTY));
        chk("mr_w3_inrst_dat", dat_w3, 32'h0);
        nxt();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setreq(1'b1, 32'h4);
            chk($sformatf("mr_w3_rty%0d", i), 32'(r_w3), 32'(RTY));
            nxt();
        end
        setreq(1'b1, 32'h4);
        chk("mr_w3_ack", 32'(r_w3), 32'(ACK));
        chk("mr_w3_dat", dat_w3, 32'hA1A1_0001);
        nxt();
        setreq(1'b0, 32'h0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
